// File: rtl/clk_tick_sync_pkg.sv
// Shared definitions for the clock-tick synchronizer: debounce FSM state
// encodings and default parameter values used by the top and its interface.
package clk_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 10 ms at 100 MHz
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int CNT_W_DEF           = 32;

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_CHK_HI  = 2'd1,
    BTN_PRESSED = 2'd2,
    BTN_CHK_LO  = 2'd3
  } btn_state_t;

endpackage

// File: rtl/clk_tick_sync_if.sv
// Signal bundle between the board-side stimulus (slow clock, button, mode)
// and the tick synchronizer. tick_count exists only when TICK_COUNT_EN is
// defined.
interface clk_tick_sync_if
`ifdef TICK_COUNT_EN
  #(parameter int CNT_W = clk_pkg::CNT_W_DEF)
`endif
  ;

  logic slow_clk_in;
  logic step_btn;
  logic run_en;
  logic tick;
  logic btn_level;
`ifdef TICK_COUNT_EN
  logic [CNT_W-1:0] tick_count;
`endif

  modport master (
    output slow_clk_in, step_btn, run_en,
`ifdef TICK_COUNT_EN
    input  tick_count,
`endif
    input  tick, btn_level
  );

  modport slave (
    input  slow_clk_in, step_btn, run_en,
`ifdef TICK_COUNT_EN
    output tick_count,
`endif
    output tick, btn_level
  );

endinterface

// File: rtl/clk_tick_sync_sync_ff.sv
// Multi-stage single-bit synchronizer with asynchronous active-high reset.
// Legal depth is 2..4 stages.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage <= '0;
    else     stage <= {stage[SYNC_STAGES-2:0], d};
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/clk_tick_sync.sv
// Brings an asynchronous slow clock and a bouncy single-step button into the
// original_clk domain and issues a one-cycle tick enable, either on each slow
// clock rising edge (run_en=1) or on each debounced press (run_en=0).
// Optional feature macro: TICK_COUNT_EN adds the tick_count output.
//
// Debounce FSM states:
//   state        | meaning
//   BTN_IDLE     | button released and stable, btn_level=0
//   BTN_CHK_HI   | input went high, counting stable-high cycles
//   BTN_PRESSED  | button pressed and stable, btn_level=1
//   BTN_CHK_LO   | input went low, counting stable-low cycles
module clk_tick_sync
  import clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
`ifdef TICK_COUNT_EN
  ,
  parameter int CNT_W           = CNT_W_DEF
`endif
) (
  input  logic            original_clk,
  input  logic            rst,
  clk_tick_sync_if.slave  bus
);

  localparam int             DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic slow_sync;
  logic btn_sync;
  logic run_sync;
  logic slow_prev;
  logic rise;

  btn_state_t      state;
  btn_state_t      state_nxt;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_nxt;
  logic            press_evt;
  logic            btn_level;
  logic            tick_q;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_slow (
    .clk (original_clk),
    .rst (rst),
    .d   (bus.slow_clk_in),
    .q   (slow_sync)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
    .clk (original_clk),
    .rst (rst),
    .d   (bus.step_btn),
    .q   (btn_sync)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
    .clk (original_clk),
    .rst (rst),
    .d   (bus.run_en),
    .q   (run_sync)
  );

  // Remember the previous synchronized slow clock for rising-edge detection.
  always_ff @(posedge original_clk or posedge rst) begin
    if (rst) slow_prev <= 1'b0;
    else     slow_prev <= slow_sync;
  end

  assign rise = slow_sync & ~slow_prev;

  // Debounce state and stability counter register.
  always_ff @(posedge original_clk or posedge rst) begin
    if (rst) begin
      state  <= BTN_IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Next-state logic; the counter restarts on every state entry so it never
  // wraps.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    case (state)
      BTN_IDLE: begin
        if (btn_sync) begin
          state_nxt  = BTN_CHK_HI;
          db_cnt_nxt = '0;
        end
      end
      BTN_CHK_HI: begin
        if (!btn_sync) begin
          state_nxt  = BTN_IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = BTN_PRESSED;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      BTN_PRESSED: begin
        if (!btn_sync) begin
          state_nxt  = BTN_CHK_LO;
          db_cnt_nxt = '0;
        end
      end
      BTN_CHK_LO: begin
        if (btn_sync) begin
          state_nxt  = BTN_PRESSED;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = BTN_IDLE;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt  = BTN_IDLE;
        db_cnt_nxt = '0;
      end
    endcase
  end

  // Debounced level follows the stable states; press_evt marks the single
  // cycle in which a press is accepted.
  always_comb begin
    btn_level = 1'b0;
    press_evt = 1'b0;
    case (state)
      BTN_PRESSED, BTN_CHK_LO: btn_level = 1'b1;
      default:                 btn_level = 1'b0;
    endcase
    if (state == BTN_CHK_HI && btn_sync && db_cnt == DB_LAST) press_evt = 1'b1;
  end

  // Registered tick: the current mode picks one event source, the other is
  // dropped rather than queued.
  always_ff @(posedge original_clk or posedge rst) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= run_sync ? rise : press_evt;
  end

  assign bus.tick      = tick_q;
  assign bus.btn_level = btn_level;

`ifdef TICK_COUNT_EN
  logic [CNT_W-1:0] tick_cnt;

  // Running total of issued ticks, wrapping at full scale.
  always_ff @(posedge original_clk or posedge rst) begin
    if (rst)         tick_cnt <= '0;
    else if (tick_q) tick_cnt <= tick_cnt + CNT_W'(1);
  end

  assign bus.tick_count = tick_cnt;
`endif

endmodule

// File: tb/tb_clk_tick_sync.sv
// Self-checking bench for clk_tick_sync. A behavioural model built from delay
// lines and run-length counting predicts tick, btn_level and (with
// TICK_COUNT_EN) tick_count every cycle; directed phases add tick-count checks.
module tb_clk_tick_sync;

  localparam int DC = 8;
  localparam int SS = 2;
`ifdef TICK_COUNT_EN
  localparam int CW = 3;
`endif

  logic original_clk = 1'b0;
  logic rst = 1'b1;

  always #5 original_clk = ~original_clk;

`ifdef TICK_COUNT_EN
  clk_tick_sync_if #(.CNT_W(CW)) bus ();
`else
  clk_tick_sync_if bus ();
`endif

  clk_tick_sync #(
    .DEBOUNCE_CYCLES (DC),
    .SYNC_STAGES     (SS)
`ifdef TICK_COUNT_EN
    ,
    .CNT_W           (CW)
`endif
  ) dut (
    .original_clk (original_clk),
    .rst          (rst),
    .bus          (bus)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  int ph_ticks = 0;

  // slow clock generator state
  int hp = 0;
  int hp_cnt = 0;
  bit slow_rand = 0;

  // reference model state
  bit sq[$];
  bit bq[$];
  bit rq[$];
  bit last_i;
  int run_len;
  bit m_level;
  bit m_tick;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq.delete(); bq.delete(); rq.delete();
    for (int k = 0; k < SS + 2; k++) begin
      sq.push_back(1'b0); bq.push_back(1'b0); rq.push_back(1'b0);
    end
    last_i = 1'b0; run_len = 0; m_level = 1'b0; m_tick = 1'b0; m_cnt = 0;
  endtask

  // Inputs as seen SS edges ago reach the FSM/edge logic now; the level flips
  // once the last DC+1 samples agree on the opposite value.
  task automatic model_edge();
    bit i_b, a, p, m, press;
    sq.push_front(bus.slow_clk_in); void'(sq.pop_back());
    bq.push_front(bus.step_btn);    void'(bq.pop_back());
    rq.push_front(bus.run_en);      void'(rq.pop_back());
    i_b = bq[SS]; a = sq[SS]; p = sq[SS+1]; m = rq[SS];
    if (i_b == last_i) run_len++;
    else begin run_len = 1; last_i = i_b; end
    press = 1'b0;
    if (run_len >= DC + 1 && i_b != m_level) begin
      m_level = i_b;
      press = i_b;
    end
    m_tick = m ? (a & ~p) : press;
`ifdef TICK_COUNT_EN
    m_cnt = (m_cnt + int'(m_tick)) % (1 << CW);
`endif
  endtask

  task automatic step();
    @(posedge original_clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check("tick", bus.tick, m_tick);
    check("btn_level", bus.btn_level, m_level);
`ifdef TICK_COUNT_EN
    check("tick_count", bus.tick_count, m_cnt);
`endif
    if (bus.tick === 1'b1) ph_ticks++;
    if (hp > 0) begin
      hp_cnt++;
      if (hp_cnt >= hp) begin
        hp_cnt = 0;
        bus.slow_clk_in = ~bus.slow_clk_in;
        if (slow_rand) hp = $urandom_range(3, 12);
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_hp(input int h);
    hp = h;
    hp_cnt = 0;
  endtask

  initial begin
    model_reset();
    bus.slow_clk_in = 1'b0;
    bus.step_btn    = 1'b0;
    bus.run_en      = 1'b0;

    // reset held, then released with slow clock toggling in step mode
    run_cycles(3);
    rst = 1'b0;
    set_hp(5);
    ph_ticks = 0;
    run_cycles(100);
    check("reset_release_no_tick", ph_ticks, 0);
    check("reset_release_level", bus.btn_level, 0);

    // free-run: period 20, five rising edges
    set_hp(0);
    bus.slow_clk_in = 1'b0;
    bus.run_en = 1'b1;
    run_cycles(10);
    ph_ticks = 0;
    set_hp(10);
    run_cycles(100);
    set_hp(0);
    run_cycles(5);
    check("run_five_ticks", ph_ticks, 5);

    // slow clock stuck high in run mode
    bus.slow_clk_in = 1'b1;
    run_cycles(10);
    ph_ticks = 0;
    run_cycles(50);
    check("stuck_high_no_tick", ph_ticks, 0);
    bus.slow_clk_in = 1'b0;

    // step mode: bouncy press then hold
    bus.run_en = 1'b0;
    run_cycles(5);
    ph_ticks = 0;
    bus.step_btn = 1'b1; run_cycles(3);
    bus.step_btn = 1'b0; run_cycles(3);
    bus.step_btn = 1'b1; run_cycles(3);
    bus.step_btn = 1'b0; run_cycles(3);
    check("bounce_no_tick", ph_ticks, 0);
    bus.step_btn = 1'b1; run_cycles(20);
    check("press_one_tick", ph_ticks, 1);
    check("press_level_high", bus.btn_level, 1);
    run_cycles(30);
    check("hold_no_more_ticks", ph_ticks, 1);

    // bouncy release, then re-press
    bus.step_btn = 1'b0; run_cycles(3);
    bus.step_btn = 1'b1; run_cycles(2);
    bus.step_btn = 1'b0; run_cycles(20);
    check("release_level_low", bus.btn_level, 0);
    check("release_no_tick", ph_ticks, 1);
    bus.step_btn = 1'b1; run_cycles(20);
    check("repress_second_tick", ph_ticks, 2);
    bus.step_btn = 1'b0; run_cycles(20);

    // run mode: press acceptance coincides with a slow clock rise
    bus.run_en = 1'b1;
    run_cycles(5);
    ph_ticks = 0;
    bus.step_btn = 1'b1;
    run_cycles(8);
    bus.slow_clk_in = 1'b1;
    run_cycles(20);
    check("coincide_one_tick", ph_ticks, 1);
    bus.run_en = 1'b0;
    run_cycles(20);
    check("switch_held_no_tick", ph_ticks, 1);
    bus.slow_clk_in = 1'b0;
    bus.step_btn = 1'b0; run_cycles(20);
    bus.step_btn = 1'b1; run_cycles(20);
    check("switch_repress_tick", ph_ticks, 2);
    bus.step_btn = 1'b0; run_cycles(20);

    // reset in the middle of a press debounce
    ph_ticks = 0;
    bus.step_btn = 1'b1;
    run_cycles(8);
    rst = 1'b1;
    bus.step_btn = 1'b0;
    run_cycles(3);
    rst = 1'b0;
    run_cycles(30);
    check("rst_mid_debounce_no_tick", ph_ticks, 0);
    check("rst_mid_debounce_level", bus.btn_level, 0);

    // randomized mix of modes, slow clock periods and bouncy presses
    slow_rand = 1;
    for (int it = 0; it < 60; it++) begin
      bus.run_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) set_hp(0);
      else if (hp == 0) set_hp($urandom_range(3, 12));
      for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
        bus.step_btn = ~bus.step_btn;
        run_cycles($urandom_range(1, 6));
      end
      bus.step_btn = 1'($urandom_range(0, 1));
      run_cycles($urandom_range(5, 25));
    end
    slow_rand = 0;
    set_hp(0);
    bus.slow_clk_in = 1'b0;
    bus.step_btn = 1'b0;
    run_cycles(20);

`ifdef TICK_COUNT_EN
    // nine ticks wrap a 3-bit counter to 1
    rst = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    bus.run_en = 1'b1;
    run_cycles(5);
    ph_ticks = 0;
    set_hp(5);
    run_cycles(90);
    set_hp(0);
    run_cycles(5);
    check("wrap_nine_ticks", ph_ticks, 9);
    check("wrap_count_one", bus.tick_count, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_tick_sync.md
Name: clk_tick_sync

Overview:
Receiving end of the design's clock-division scheme. Takes an asynchronous slow clock (from the divider or an external source) and a raw single-step push-button into the fast board-clock domain. Produces a clean one-cycle tick enable for the processor core, in either free-run mode or debounced single-step mode. The core is clocked by original_clk and gated by tick, so it never runs on a derived clock.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, original_clk cycles the button must be stable before a level change is accepted (10 ms at 100 MHz); minimum 2.
SYNC_STAGES, 2, flip-flop stages in each input synchronizer; legal range 2..4.
CNT_W, 32, width of tick_count (optional feature only).

Ports:
original_clk  input  1  fast board clock; all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
slow_clk_in  input  1  asynchronous slow clock; its rising edge is the free-run event.
step_btn  input  1  raw, bouncy, asynchronous button; high = pressed.
run_en  input  1  mode select; 1 = free-run, 0 = single-step. Treated as quasi-static and synchronized like the other inputs.
tick  output  1  one-cycle enable pulse.
btn_level  output  1  debounced button level.
tick_count  output  CNT_W  total ticks issued (TICK_COUNT_EN only).

Behaviour:
- Reset: all synchronizer flops, edge registers, FSM and counters clear. Outputs: tick=0, btn_level=0, tick_count=0. Reset asserted mid-press or mid-debounce aborts to BTN_IDLE; no tick is emitted on release of reset.
- Synchronizers: slow_clk_in, step_btn and run_en each pass through SYNC_STAGES flops. The synchronized slow clock feeds a previous-value register; rise = sync & ~prev.
- Debounce FSM (state encoded as a 2-bit constant):
  - BTN_IDLE: btn_level=0. Synchronized button high → BTN_CHK_HI, counter := 0.
  - BTN_CHK_HI: input low → BTN_IDLE. Otherwise counter increments. At counter == DEBOUNCE_CYCLES-1 → BTN_PRESSED, btn_level := 1, press_evt pulses for 1 cycle.
  - BTN_PRESSED: input low → BTN_CHK_LO, counter := 0.
  - BTN_CHK_LO: input high → BTN_PRESSED. At counter == DEBOUNCE_CYCLES-1 → BTN_IDLE, btn_level := 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps; it is cleared on every state entry.
- Tick generation (registered):
  - tick = (run_en_sync & rise) | (~run_en_sync & press_evt).
  - Latency from the slow_clk_in edge to tick: SYNC_STAGES+1 cycles.
  - Latency from the end of stable press to tick: 1 cycle after press_evt.
- Exactly one tick per qualifying event; tick is never high two consecutive cycles.
- If rise and press_evt coincide, the mode decides; the other event is dropped and is not queued.
- Mode change: the new mode takes effect SYNC_STAGES cycles after run_en changes. A button held during the switch to step mode produces no tick until released and re-pressed.
- slow_clk_in stuck high or low: no ticks in run mode.
- slow_clk_in faster than original_clk/4: out of spec; edges may be lost.

Optional Feature:
Macro TICK_COUNT_EN.
- Defined: tick_count increments by 1 on every cycle tick=1 and wraps from 2^CNT_W-1 to 0; cleared by rst.
- Undefined: the tick_count port and its counter are omitted entirely; all other behaviour is identical.

Decomposition:
- Shared package clk_pkg holds: the BTN_* state encodings, the default DEBOUNCE_CYCLES, and the default CNT_W.
- One sub-module, sync_ff: a SYNC_STAGES-deep single-bit synchronizer with async reset. It is instantiated three times.
- Debounce FSM and tick logic stay in the top module.

Test Plan:
- Reset release with slow_clk_in toggling and run_en=0: tick stays 0, btn_level=0, tick_count=0 for 100 cycles.
- run_en=1, SYNC_STAGES=2, slow_clk_in period 20 cycles, 5 periods: exactly 5 ticks, each 3 cycles after a rising edge, each 1 cycle wide; tick_count=5.
- run_en=0, DEBOUNCE_CYCLES=8: step_btn bounces 1-0-1 every 3 cycles, then held high for 20 cycles:
  - no tick during the bounce;
  - btn_level rises after 8 stable cycles;
  - exactly 1 tick;
  - holding the button longer produces no further tick.
- Release the button with a bounce shorter than 8 cycles, then a stable low: btn_level falls once; no tick. A re-press yields a second tick.
- run_en=1 with a press completing in the same cycle as rise: exactly one tick. Then switch to run_en=0 while the button is held: no tick until release and re-press.
- Assert rst in BTN_CHK_HI with counter=5: state returns to idle; no tick after rst deasserts. With TICK_COUNT_EN and CNT_W=3: 9 ticks leave tick_count=1.
